// File: rtl/pc_pkg.sv
// Shared definitions for the PC fetch controller: FSM state encodings and
// parameter defaults.
package pc_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RUN    = 2'd1,
        ST_STALL  = 2'd2,
        ST_HALTED = 2'd3
    } fetch_state_t;

    localparam int          PC_W_DEFAULT     = 64;
    localparam logic [63:0] RESET_PC_DEFAULT = 64'd0;

endpackage

// File: rtl/pc_incr.sv
// Combinational sequential-PC generator: PC + 1, wrapping modulo 2^PC_W.
module pc_incr #(
    parameter int PC_W = 64
) (
    input  logic [PC_W-1:0] pc,
    output logic [PC_W-1:0] pc_plus1
);

    localparam logic [PC_W-1:0] ONE = PC_W'(1);

    assign pc_plus1 = pc + ONE;

endmodule

// File: rtl/pc_fetch_ctrl.sv
// Instruction-fetch PC controller: IDLE/RUN/STALL/HALTED FSM, the PC register
// driving a synchronous imem, and the pc_q/fetch_valid stage aligned to imem data.
module pc_fetch_ctrl
    import pc_pkg::*;
#(
    parameter int              PC_W     = PC_W_DEFAULT,
    parameter logic [PC_W-1:0] RESET_PC = PC_W'(RESET_PC_DEFAULT)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            en,
    input  logic            stall,
    input  logic            branch_taken,
    input  logic [PC_W-1:0] branch_target,
    input  logic            halt_req,
    output logic [PC_W-1:0] imem_addr,
    output logic            fetch_valid,
    output logic [PC_W-1:0] pc_q,
    output logic            flush,
    output logic [1:0]      state
);

    fetch_state_t    state_reg, state_next;
    logic [PC_W-1:0] pc_reg, pc_next;
    logic [PC_W-1:0] pc_q_reg, pc_q_next;
    logic            fetch_valid_reg, fetch_valid_next;
    logic            flush_next;
    logic [PC_W-1:0] pc_plus1;

    pc_incr #(
        .PC_W(PC_W)
    ) u_pc_incr (
        .pc      (pc_reg),
        .pc_plus1(pc_plus1)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg       <= ST_IDLE;
            pc_reg          <= RESET_PC;
            pc_q_reg        <= RESET_PC;
            fetch_valid_reg <= 1'b0;
        end else begin
            state_reg       <= state_next;
            pc_reg          <= pc_next;
            pc_q_reg        <= pc_q_next;
            fetch_valid_reg <= fetch_valid_next;
        end
    end

    // Events resolved in priority order: halt, branch, stall, en=0, increment.
    always_comb begin
        state_next = state_reg;
        pc_next    = pc_reg;
        flush_next = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                if (halt_req) begin
                    state_next = ST_HALTED;
                end else if (en) begin
                    state_next = ST_RUN;
                end
            end
            ST_RUN, ST_STALL: begin
                if (halt_req) begin
                    state_next = ST_HALTED;
                end else if (branch_taken) begin
                    state_next = ST_RUN;
                    pc_next    = branch_target;
                    flush_next = 1'b1;
                end else if (stall) begin
                    state_next = ST_STALL;
                end else if (!en) begin
                    state_next = ST_IDLE;
                end else begin
                    state_next = ST_RUN;
                    pc_next    = pc_plus1;
                end
            end
            ST_HALTED: begin
                state_next = ST_HALTED;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase

        // Only a RUN cycle issues a real fetch; a redirect kills the wrong-path word.
        fetch_valid_next = (state_reg == ST_RUN) && !flush_next;
        pc_q_next        = (state_reg == ST_STALL) ? pc_q_reg : pc_reg;
    end

    assign imem_addr   = pc_reg;
    assign pc_q        = pc_q_reg;
    assign fetch_valid = fetch_valid_reg;
    assign flush       = flush_next;
    assign state       = state_reg;

endmodule

// File: tb/tb_pc_fetch_ctrl.sv
// Self-checking bench for pc_fetch_ctrl: directed scenarios plus a random run,
// all compared against a rule-level reference model.
module tb_pc_fetch_ctrl;

    localparam int W = 64;
    localparam logic [1:0] M_IDLE = 2'd0, M_RUN = 2'd1, M_STALL = 2'd2, M_HALT = 2'd3;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         en = 1'b0, stall = 1'b0, branch_taken = 1'b0, halt_req = 1'b0;
    logic [W-1:0] branch_target = '0;
    logic [W-1:0] imem_addr, pc_q;
    logic         fetch_valid, flush;
    logic [1:0]   state;

    int vecs = 0;
    int miscompares = 0;

    logic [W-1:0] m_pc, m_pcq;
    logic         m_fv;
    logic [1:0]   m_st;
    logic         fl;

    pc_fetch_ctrl #(.PC_W(W), .RESET_PC('0)) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .stall(stall),
        .branch_taken(branch_taken), .branch_target(branch_target),
        .halt_req(halt_req), .imem_addr(imem_addr), .fetch_valid(fetch_valid),
        .pc_q(pc_q), .flush(flush), .state(state)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vecs++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_pc = '0; m_pcq = '0; m_fv = 1'b0; m_st = M_IDLE;
    endtask

    task automatic chk_all(input string tag);
        chk({tag, ".imem_addr"}, imem_addr, m_pc);
        chk({tag, ".pc_q"}, pc_q, m_pcq);
        chk({tag, ".fetch_valid"}, {63'd0, fetch_valid}, {63'd0, m_fv});
        chk({tag, ".state"}, {62'd0, state}, {62'd0, m_st});
    endtask

    // One clock of stimulus; called at posedge+1, returns at the next posedge+1.
    task automatic step(input logic e, input logic s, input logic b,
                        input logic [W-1:0] t, input logic h, output logic fl_seen);
        logic exp_fl;
        en = e; stall = s; branch_taken = b; branch_target = t; halt_req = h;
        #3;
        exp_fl = b && !h && (m_st == M_RUN || m_st == M_STALL);
        fl_seen = flush;
        chk("flush", {63'd0, flush}, {63'd0, exp_fl});
        @(posedge clk); #1;
        m_fv  = (m_st == M_RUN) && !exp_fl;
        m_pcq = (m_st == M_STALL) ? m_pcq : m_pc;
        if (m_st == M_HALT) begin
            m_st = M_HALT;
        end else if (h) begin
            m_st = M_HALT;
        end else if (m_st == M_IDLE) begin
            if (e) m_st = M_RUN;
        end else if (b) begin
            m_pc = t; m_st = M_RUN;
        end else if (s) begin
            m_st = M_STALL;
        end else if (!e) begin
            m_st = M_IDLE;
        end else begin
            m_pc = m_pc + 1'b1; m_st = M_RUN;
        end
        chk_all("step");
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        en = 1'b0; stall = 1'b0; branch_taken = 1'b0; halt_req = 1'b0;
        @(posedge clk); #1;
        model_reset();
        chk_all("reset");
        rst_n = 1'b1;
    endtask

    initial begin
        model_reset();
        @(posedge clk); @(posedge clk); #1;
        chk("rst.imem_addr", imem_addr, 64'd0);
        chk("rst.pc_q", pc_q, 64'd0);
        chk("rst.fetch_valid", {63'd0, fetch_valid}, 64'd0);
        chk("rst.flush", {63'd0, flush}, 64'd0);
        chk("rst.state", {62'd0, state}, 64'd0);
        rst_n = 1'b1;

        // Sequential fetch from reset.
        for (int k = 0; k < 5; k++) begin
            step(1, 0, 0, '0, 0, fl);
            chk("seq.imem_addr", imem_addr, 64'(k));
        end
        chk("seq.pc_q_lag", pc_q, 64'd3);
        chk("seq.valid", {63'd0, fetch_valid}, 64'd1);
        step(1, 0, 0, '0, 0, fl);
        chk("seq.pc5", imem_addr, 64'd5);

        // Stall for three cycles at PC=5, then release.
        for (int k = 0; k < 3; k++) step(1, 1, 0, '0, 0, fl);
        chk("stall.hold", imem_addr, 64'd5);
        chk("stall.state", {62'd0, state}, {62'd0, M_STALL});
        chk("stall.valid", {63'd0, fetch_valid}, 64'd0);
        step(1, 0, 0, '0, 0, fl);
        chk("stall.release", imem_addr, 64'd6);
        step(1, 0, 0, '0, 0, fl);
        chk("br.pc7", imem_addr, 64'd7);

        // Branch with simultaneous stall: branch wins.
        step(1, 1, 1, 64'h40, 0, fl);
        chk("br.flush_pulse", {63'd0, fl}, 64'd1);
        chk("br.target", imem_addr, 64'h40);
        chk("br.killed", {63'd0, fetch_valid}, 64'd0);
        step(1, 0, 0, '0, 0, fl);
        chk("br.valid", {63'd0, fetch_valid}, 64'd1);
        chk("br.pc_q", pc_q, 64'h40);

        // Wrap from all-ones.
        step(1, 0, 1, '1, 0, fl);
        step(1, 0, 0, '0, 0, fl);
        chk("wrap.zero", imem_addr, 64'd0);
        chk("wrap.noflush", {63'd0, fl}, 64'd0);
        step(1, 0, 0, '0, 0, fl);

        // Halt beats a simultaneous branch; afterwards everything is ignored.
        step(1, 0, 1, 64'h123, 1, fl);
        chk("halt.noflush", {63'd0, fl}, 64'd0);
        chk("halt.state", {62'd0, state}, {62'd0, M_HALT});
        chk("halt.frozen", imem_addr, 64'd1);
        for (int k = 0; k < 3; k++) step(1, 0, 1, 64'h55, 0, fl);
        chk("halt.stuck", imem_addr, 64'd1);

        // Asynchronous reset mid-stall with a branch pending.
        do_reset();
        for (int k = 0; k < 4; k++) step(1, 0, 0, '0, 0, fl);
        step(1, 1, 0, '0, 0, fl);
        stall = 1'b1; branch_taken = 1'b1; branch_target = 64'h99;
        #2;
        chk("arst.pre_flush", {63'd0, flush}, 64'd1);
        rst_n = 1'b0;
        #1;
        chk("arst.imem_addr", imem_addr, 64'd0);
        chk("arst.pc_q", pc_q, 64'd0);
        chk("arst.fetch_valid", {63'd0, fetch_valid}, 64'd0);
        chk("arst.flush", {63'd0, flush}, 64'd0);
        chk("arst.state", {62'd0, state}, 64'd0);
        @(posedge clk); #1;
        do_reset();

        // Random traffic against the model.
        for (int i = 0; i < 400; i++) begin
            if (i % 97 == 96) do_reset();
            step($urandom_range(0, 9) != 0, $urandom_range(0, 3) == 0,
                 $urandom_range(0, 4) == 0, {$urandom, $urandom},
                 $urandom_range(0, 63) == 0, fl);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vecs, miscompares);
        $finish;
    end

endmodule

// File: doc/pc_fetch_ctrl.md
PC_FETCH_CTRL -- requirements
Module: pc_fetch_ctrl

Interface
REQ-001 The block SHALL have parameter PC_W, default 64, giving the width of every PC-valued port.
REQ-002 The block SHALL have parameter RESET_PC, default 0, giving the PC loaded at reset.
REQ-003 The block SHALL have port clk  input  1  as its single clock; all state SHALL update on the rising edge.
REQ-004 The block SHALL have port rst_n  input  1  as its reset, asynchronous and active-low.
REQ-005 The block SHALL have port en  input  1  to start or continue fetching.
REQ-006 The block SHALL have port stall  input  1  to hold the PC (pipeline hazard).
REQ-007 The block SHALL have port branch_taken  input  1  to redirect the PC this cycle.
REQ-008 The block SHALL have port branch_target  input  PC_W  as the redirect address.
REQ-009 The block SHALL have port halt_req  input  1  to request a stop of fetching.
REQ-010 The block SHALL have port imem_addr  output  PC_W  as the current PC driven to the synchronous instruction memory.
REQ-011 The block SHALL have port fetch_valid  output  1  to mark the instruction for pc_q as valid this cycle.
REQ-012 The block SHALL have port pc_q  output  PC_W  as the PC of the instruction now at the imem output, one cycle behind imem_addr.
REQ-013 The block SHALL have port flush  output  1  as a one-cycle pulse on a taken redirect.
REQ-014 The block SHALL have port state  output  2  as the FSM state encoding.

Function
REQ-015 The FSM SHALL have four states: IDLE=0, RUN=1, STALL=2, HALTED=3.
REQ-016 In IDLE the PC SHALL hold and fetch_valid SHALL be 0; en=1 SHALL move the FSM to RUN on the next edge.
REQ-017 In RUN with no other event, the next PC SHALL be PC+1, modulo 2^PC_W; all-ones SHALL wrap to 0 with no flag.
REQ-018 Event priority each cycle SHALL be halt_req > branch_taken > stall > en=0 > increment.
REQ-019 halt_req=1 in any state but HALTED SHALL move the FSM to HALTED and freeze the PC; HALTED SHALL be left only by reset.
REQ-020 branch_taken=1 in RUN or STALL SHALL load branch_target as the next PC, pulse flush=1 for that cycle, return the FSM to RUN, and override a simultaneous stall.
REQ-021 branch_taken SHALL be ignored in IDLE and HALTED, with flush staying 0.
REQ-022 stall=1 in RUN SHALL move the FSM to STALL and hold the PC; stall=0 in STALL SHALL return it to RUN, incrementing on the following cycle.
REQ-023 en=0 in RUN or STALL SHALL return the FSM to IDLE and hold the PC.
REQ-024 pc_q SHALL register imem_addr each cycle and SHALL hold during STALL.
REQ-025 fetch_valid SHALL be 1 only in the cycle after a RUN cycle in which no flush occurred.
REQ-026 fetch_valid SHALL be 0 in the cycle after a flush, killing the wrong-path instruction.
REQ-027 Latency from a branch_taken edge to imem_addr=branch_target SHALL be 1 cycle, and to fetch_valid=1 with pc_q=branch_target SHALL be 2 cycles.

Reset
REQ-028 rst_n=0 SHALL immediately and asynchronously set imem_addr=RESET_PC, pc_q=RESET_PC, fetch_valid=0, flush=0 and state=IDLE, including mid-stall, mid-branch and in HALTED.
REQ-029 After rst_n deasserts, the first fetch_valid SHALL come no earlier than 2 edges after en=1.

Structure
REQ-030 The state encodings and the default RESET_PC SHALL be defined in the shared package pc_pkg.
REQ-031 The increment SHALL be done by one sub-module, pc_incr (combinational PC+1, PC_W wide, fixed constant one).
REQ-032 The FSM, PC register and pc_q/fetch_valid pipeline register SHALL be in pc_fetch_ctrl; it SHALL have no other storage.

Verification
REQ-033 The bench SHALL check: reset, then en=1 for 5 cycles -> imem_addr 0,1,2,3,4; pc_q lags by 1; fetch_valid=1 from cycle 2.
REQ-034 The bench SHALL check: PC=5, stall=1 for 3 cycles -> imem_addr holds 5, state=STALL, fetch_valid=0; stall release -> 6 next.
REQ-035 The bench SHALL check: PC=7, branch_taken=1, target=0x40, stall=1 at the same time -> flush pulse, imem_addr=0x40 next edge, fetch_valid=0 then 1 with pc_q=0x40.
REQ-036 The bench SHALL check: PC=all-ones in RUN -> next imem_addr=0, no stall or flush.
REQ-037 The bench SHALL check: halt_req=1 with branch_taken=1 at the same time -> state=HALTED, PC frozen, flush=0; later en and branch are ignored.
REQ-038 The bench SHALL check: rst_n=0 asserted between clock edges during STALL -> outputs go to reset values before the next edge.
